// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin CPU/DMA arbiter that serializes accesses to one
// single-ported synchronous RAM, one registered access and one ack pulse per transfer.
module ram_arbiter #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_ack_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   input  logic              dma_req_i,
   input  logic              dma_we_i,
   input  logic [ADDR_W-1:0] dma_addr_i,
   input  logic [DATA_W-1:0] dma_wdata_i,
   output logic              dma_ack_o,
   output logic [DATA_W-1:0] dma_rdata_o,
   output logic              ram_en_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   output logic              busy_o
);
   typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, ACK} state_e;
   localparam logic DMA = 1'b1;
   state_e state_q, state_d;
   logic own_q, own_d, we_q, we_d, last_q, last_d, gnt_dma;
   logic ram_en_q, ram_en_d, ram_we_q, ram_we_d, busy_q, busy_d;
   logic cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d, cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
   assign cpu_ack_o   = cpu_ack_q;
   assign dma_ack_o   = dma_ack_q;
   assign cpu_rdata_o = cpu_rdata_q;
   assign dma_rdata_o = dma_rdata_q;
   assign ram_en_o    = ram_en_q;
   assign ram_we_o    = ram_we_q;
   assign ram_addr_o  = ram_addr_q;
   assign ram_wdata_o = ram_wdata_q;
   assign busy_o      = busy_q;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         own_q       <= 1'b0;
         we_q        <= 1'b0;
         last_q      <= DMA;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         own_q       <= own_d;
         we_q        <= we_d;
         last_q      <= last_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         dma_ack_q   <= dma_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
         busy_q      <= busy_d;
      end
   end
   always_comb begin
      state_d     = state_q;
      own_d       = own_q;
      we_d        = we_q;
      last_d      = last_q;
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      cpu_ack_d   = 1'b0;
      dma_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      // DMA wins when alone, or on a tie when the CPU owned the previous grant
      gnt_dma     = dma_req_i & (~cpu_req_i | ~last_q);
      case (state_q)
         IDLE: if (cpu_req_i | dma_req_i) begin
            own_d       = gnt_dma;
            last_d      = gnt_dma;
            we_d        = gnt_dma ? dma_we_i : cpu_we_i;
            ram_en_d    = 1'b1;
            ram_we_d    = we_d;
            ram_addr_d  = gnt_dma ? dma_addr_i : cpu_addr_i;
            ram_wdata_d = gnt_dma ? dma_wdata_i : cpu_wdata_i;
            state_d     = ACCESS;
         end
         ACCESS: begin
            cpu_ack_d = we_q & ~own_q;
            dma_ack_d = we_q & own_q;
            state_d   = we_q ? ACK : RDWAIT;
         end
         RDWAIT: begin
            cpu_rdata_d = own_q ? cpu_rdata_q : ram_rdata_i;
            dma_rdata_d = own_q ? ram_rdata_i : dma_rdata_q;
            cpu_ack_d   = ~own_q;
            dma_ack_d   = own_q;
            state_d     = ACK;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a
// transaction-schedule model and a behavioural RAM.
module tb_ram_arbiter;
   logic clk = 1'b0, rst_n;
   logic cpu_req, cpu_we, dma_req, dma_we;
   logic [8:0] cpu_addr, dma_addr, ram_addr;
   logic [31:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, ram_wdata, ram_rdata;
   logic cpu_ack, dma_ack, ram_en, ram_we, busy;
   int errors = 0, checks = 0, cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   ram_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
      .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
      .dma_ack_o(dma_ack), .dma_rdata_o(dma_rdata),
      .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
      .ram_rdata_i(ram_rdata), .busy_o(busy));

   // RAM macro; preloaded with a recognisable pattern on the first edge
   logic [31:0] mem [512];
   bit mem_init = 0;
   initial ram_rdata = '0;
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 512; i++) mem[i] <= 32'hC0DE0000 | i;
         mem_init <= 1'b1;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else ram_rdata <= mem[ram_addr];
      end
   end

   task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   // Model: a transfer is a schedule counted in cycles since its grant.
   // Phase 1 is the RAM cycle; the ack lands in phase 2 (write) or 3 (read).
   int ph = 0;
   bit started = 0;
   logic m_own, m_we, m_last;
   logic [8:0] m_addr;
   logic [31:0] m_wdata, m_crd, m_drd;
   logic [31:0] m_mem [512];
   always @(posedge clk) begin
      if (!started) for (int i = 0; i < 512; i++) m_mem[i] = 32'hC0DE0000 | i;
      started = 1;
      if (!rst_n) begin
         ph = 0; m_last = 1'b1; m_own = 1'b0; m_we = 1'b0;
         m_addr = '0; m_wdata = '0; m_crd = '0; m_drd = '0;
      end else if (ph != 0) begin
         ph = (ph == (m_we ? 2 : 3)) ? 0 : ph + 1;
         if (ph == 3) begin
            if (m_own) m_drd = m_mem[m_addr];
            else m_crd = m_mem[m_addr];
         end
      end else if (cpu_req || dma_req) begin
         m_own   = (cpu_req && dma_req) ? !m_last : dma_req;
         m_last  = m_own;
         m_we    = m_own ? dma_we : cpu_we;
         m_addr  = m_own ? dma_addr : cpu_addr;
         m_wdata = m_own ? dma_wdata : cpu_wdata;
         if (m_we) m_mem[m_addr] = m_wdata;
         ph = 1;
      end
   end

   always @(negedge clk) if (started) begin
      check("ram_en", ram_en, ph == 1);
      check("ram_we", ram_we, ph == 1 && m_we);
      check("ram_addr", ram_addr, m_addr);
      check("ram_wdata", ram_wdata, m_wdata);
      check("cpu_ack", cpu_ack, ph != 0 && ph == (m_we ? 2 : 3) && !m_own);
      check("dma_ack", dma_ack, ph != 0 && ph == (m_we ? 2 : 3) && m_own);
      check("cpu_rdata", cpu_rdata, m_crd);
      check("dma_rdata", dma_rdata, m_drd);
      check("busy", busy, ph != 0);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 12) begin tick(); n++; end
      check("idle_wait", busy, 0);
   endtask

   task automatic xfer(input bit d, input bit w, input logic [8:0] a, input logic [31:0] wd,
                       output logic [31:0] rd);
      int n = 0;
      logic ak;
      if (d) begin dma_req = 1; dma_we = w; dma_addr = a; dma_wdata = wd; end
      else begin cpu_req = 1; cpu_we = w; cpu_addr = a; cpu_wdata = wd; end
      do begin
         tick(); n++;
         if (ram_en) check("xfer_addr", ram_addr, a);
         ak = d ? dma_ack : cpu_ack;
      end while (!ak && n < 10);
      check("xfer_ack", ak, 1);
      rd = d ? dma_rdata : cpu_rdata;
      cpu_req = 0; dma_req = 0;
      wait_idle();
   endtask

   function automatic logic [8:0] pick_addr();
      case ($urandom_range(0, 3))
         0: return 9'h000;
         1: return 9'h1FF;
         2: return 9'($urandom_range(0, 7));
         default: return 9'($urandom_range(0, 511));
      endcase
   endfunction

   initial begin
      logic [31:0] rd;
      logic [8:0] seen_a [4];
      int seen_c [4];
      int ns, c0;
      rst_n = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 9'h0AA; cpu_wdata = '0;
      dma_req = 1; dma_we = 0; dma_addr = 9'h0BB; dma_wdata = '0;
      tick(); tick();
      check("rst_ram_en", ram_en, 0);
      check("rst_busy", busy, 0);
      check("rst_acks", {cpu_ack, dma_ack}, 0);
      check("rst_rdata", cpu_rdata | dma_rdata, 0);
      rst_n = 1;
      tick();
      check("first_grant_en", ram_en, 1);
      check("first_grant_addr", ram_addr, 9'h0AA);
      cpu_req = 0; dma_req = 0;
      wait_idle();

      cpu_req = 1; cpu_we = 1; cpu_addr = 9'h010; cpu_wdata = 32'hDEADBEEF;
      tick();
      check("wr_en_we", {ram_en, ram_we}, 2'b11);
      check("wr_addr", ram_addr, 9'h010);
      check("wr_data", ram_wdata, 32'hDEADBEEF);
      tick();
      check("wr_ack", {cpu_ack, dma_ack}, 2'b10);
      cpu_we = 0;
      tick();
      check("wr_idle", busy, 0);
      tick();
      check("rd_en_we", {ram_en, ram_we}, 2'b10);
      tick();
      check("rd_no_ack_yet", cpu_ack, 0);
      tick();
      check("rd_ack", {cpu_ack, dma_ack}, 2'b10);
      check("rd_data", cpu_rdata, 32'hDEADBEEF);
      cpu_req = 0;
      wait_idle();

      rst_n = 0;
      tick();
      rst_n = 1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 9'h001;
      dma_req = 1; dma_we = 0; dma_addr = 9'h002;
      ns = 0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (ram_en && ns < 4) begin seen_a[ns] = ram_addr; seen_c[ns] = i; ns++; end
      end
      cpu_req = 0; dma_req = 0;
      check("cont_grants", ns, 4);
      for (int k = 0; k < 4; k++) begin
         check("cont_addr", seen_a[k], (k % 2 == 1) ? 9'h002 : 9'h001);
         check("cont_cycle", seen_c[k], 1 + 4 * k);
      end
      check("cont_cpu_data", cpu_rdata, 32'hC0DE0001);
      check("cont_dma_data", dma_rdata, 32'hC0DE0002);
      wait_idle();

      dma_req = 1; dma_we = 1; dma_addr = 9'h100; dma_wdata = 32'h0000D100;
      c0 = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("dma_wr_en", ram_en, 1);
         check("dma_wr_addr", ram_addr, 9'h100 + 9'(i));
         if (i > 0) check("dma_wr_spacing", cyc - c0, 3);
         c0 = cyc;
         tick();
         check("dma_wr_ack", {dma_ack, cpu_ack}, 2'b10);
         dma_addr = 9'h101 + 9'(i); dma_wdata = 32'h0000D101 + i;
         if (i == 2) dma_req = 0;
         tick();
      end
      wait_idle();

      cpu_req = 1; cpu_we = 0; cpu_addr = 9'h003;
      tick(); tick();
      rst_n = 0;
      dma_req = 1; dma_we = 0; dma_addr = 9'h004;
      tick();
      check("rdwait_rst_ack", cpu_ack, 0);
      check("rdwait_rst_rdata", cpu_rdata, 0);
      check("rdwait_rst_busy", busy, 0);
      rst_n = 1;
      tick();
      check("post_rst_en", ram_en, 1);
      check("post_rst_addr", ram_addr, 9'h003);
      cpu_req = 0; dma_req = 0;
      wait_idle();

      xfer(0, 1, 9'h000, 32'h12345678, rd);
      xfer(0, 1, 9'h1FF, 32'hA5A5A5A5, rd);
      xfer(1, 0, 9'h1FF, 32'h0, rd);
      check("bound_1ff", rd, 32'hA5A5A5A5);
      xfer(0, 0, 9'h000, 32'h0, rd);
      check("bound_000", rd, 32'h12345678);

      for (int i = 0; i < 3000; i++) begin
         logic was_rst;
         tick();
         was_rst = !rst_n;
         rst_n = (was_rst || $urandom_range(0, 199) != 0);
         if (was_rst || cpu_ack || !cpu_req) begin
            cpu_req = $urandom_range(0, 2) != 0; cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = pick_addr(); cpu_wdata = $urandom;
         end
         if (was_rst || dma_ack || !dma_req) begin
            dma_req = $urandom_range(0, 2) != 0; dma_we = 1'($urandom_range(0, 1));
            dma_addr = pick_addr(); dma_wdata = $urandom;
         end
      end
      cpu_req = 0; dma_req = 0; rst_n = 1;
      tick();
      wait_idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the single-ported synchronous RAM shared by the CPU memory path and the DMA port. Both requesters share one RAM port. Each transfer is serialized as one registered RAM access with a one-cycle ack pulse, and a round-robin pointer guarantees fairness under contention. Sits between the CPU MAR/MDR path, the DMA engine and the RAM macro.

## Interface
Parameters:
- ADDR_W, 9, RAM word-address width (512 words)
- DATA_W, 32, data width

Ports:
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request, level
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  CPU read data, valid with read ack, held until next CPU read ack
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same widths and meaning as the cpu_* ports, DMA side
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write strobe, only with ram_en
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en with ram_we=0
- busy  out  1  high in every state except IDLE

## Operation
- All outputs are registered.
- Reset value of every output is 0: ram_*, acks, rdata regs, busy. Internal state resets to IDLE; last_owner resets to DMA, so the CPU wins the first tie.
- FSM states are IDLE, ACCESS, RDWAIT and ACK.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the requester that is not last_owner.
  - On grant: latch owner, we, addr and wdata; drive ram_en=1, ram_we=we, ram_addr, ram_wdata; update last_owner; go to ACCESS.
- ACCESS:
  - ram_en=1 for exactly this cycle.
  - Leaving ACCESS: ram_en=0 and ram_we=0.
  - Write: set the owner's ack; go to ACK.
  - Read: go to RDWAIT.
- RDWAIT: capture ram_rdata into the owner's rdata register; set the owner's ack; go to ACK.
- ACK: the owner's ack is high for this cycle only. Clear the ack; go to IDLE.
- Requester protocol: hold req, we, addr and wdata stable from assertion until ack.
  - req still high in the cycle after ack counts as a new request.
  - Inputs are sampled only in IDLE. Changes after the grant are ignored.
  - req dropped after grant: the access completes and ack is still issued.
- The non-owner's ack and rdata never change during another requester's transfer.
- Write ack does not modify rdata.
- Addresses pass through unmodified. All ADDR_W values are legal, including max 2^ADDR_W-1; there is no wrap or offset arithmetic.
- Reset low at any edge, including mid-transfer:
  - Next state is IDLE, all outputs go to 0, last_owner goes to DMA.
  - The pending transfer is abandoned and no ack is produced.
  - A RAM write whose ram_en/ram_we was high in the cycle Reset was sampled low commits in the RAM. The arbiter does not ack it.

## Timing
- Request first high in IDLE cycle N. Grant registered at the end of N.
- Cycle N+1: ram_en high, plus ram_we for a write.
- Write: ack in cycle N+2. Arbiter back in IDLE at N+3, so a new request is sampled at N+3.
- Read: ram_rdata valid in N+2. ack and rdata valid in N+3. IDLE at N+4.
- Throughput:
  - One write per 3 cycles, one read per 4 cycles.
  - Under continuous contention, grants alternate strictly CPU, DMA, CPU, …
- Lone requester: served back-to-back with no round-robin penalty.
- busy is high from N+1 through the ACK cycle.

## Test plan
- Reset: Reset=0 for 2 cycles with both req high → all outputs 0, no ram_en. Release → first ram_en belongs to CPU (ram_addr=cpu_addr).
- CPU write then read:
  - cpu_we=1, addr 0x010, data 0xDEADBEEF at N → ram_en=ram_we=1, ram_addr=0x010, ram_wdata=0xDEADBEEF in N+1; cpu_ack in N+2.
  - Then read 0x010 → cpu_ack with cpu_rdata=0xDEADBEEF 3 cycles after the request.
  - dma_ack stays 0 throughout.
- Contention: both req held, reading 0x001 (CPU) and 0x002 (DMA) → ram_addr sequence 0x001, 0x002, 0x001, 0x002 at 4-cycle spacing. Each ack goes only to its owner, with the correct data.
- Lone DMA: 3 consecutive DMA writes to 0x100–0x102 → each ack 2 cycles after its request. The ram_en pulses are 3 cycles apart.
- Reset in RDWAIT of a CPU read → no cpu_ack, cpu_rdata=0, busy=0. After release with both req high, CPU is served first.
- Boundary address: write 0xA5A5A5A5 to 0x1FF, then read back → ram_addr=0x1FF and rdata=0xA5A5A5A5. Addresses 0x000 and 0x1FF do not alias.
